mem_arbiter_16bit: RTL and testbench
====================================

# mem_arbiter_16bit

Two-port round-robin arbiter that shares the single-port 256x16 synchronous memory (`memory_16bit`) between two requesters, for example instruction fetch (port 0) and data load/store (port 1) of the 16-bit CPU. It registers the winning command onto the memory ports and accounts for the memory's one-cycle registered read. It returns read data to the winning requester with a one-cycle valid pulse. One access completes every 2 cycles when requests are back-to-back.

## Interface
- `ADDR_W`, 8, memory address width (256 words)
- `DATA_W`, 16, memory data width
- `clk`  input  1  single clock; all state on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `req0` / `req1`  input  1  access request, port 0 / 1
- `we0` / `we1`  input  1  1 = write, 0 = read; held stable while req high
- `addr0` / `addr1`  input  ADDR_W  word address; held stable while req high
- `wdata0` / `wdata1`  input  DATA_W  write data; held stable while req high
- `gnt0` / `gnt1`  output  1  one-cycle pulse: command accepted, requester may change/drop req next edge
- `rvalid0` / `rvalid1`  output  1  one-cycle pulse: rdata valid (reads only)
- `rdata0` / `rdata1`  output  DATA_W  registered read data; holds last value between pulses
- `mem_address`  output  ADDR_W  to memory `address`
- `mem_data_in`  output  DATA_W  to memory `data_in`
- `mem_write_en`  output  1  to memory `write_en`
- `mem_data_out`  input  DATA_W  from memory `data_out` (valid one cycle after address is presented)

## Operation
- FSM states:
  - IDLE: no access in flight.
  - ACCESS: command on memory ports for exactly one cycle.
  - RESP: memory `data_out` valid; capture it.
- IDLE: if any req is sampled high, pick a winner and load `mem_address` / `mem_data_in` / `mem_write_en` from it. Set that port's gnt, record winner and we, go to ACCESS. If no req, stay in IDLE.
- ACCESS: clear gnt and `mem_write_en`; go to RESP. The memory performs the write or read at this edge.
- RESP:
  - If the recorded access was a read, load `rdata<winner>` from `mem_data_out` and pulse `rvalid<winner>` next cycle.
  - Arbitrate again in the same cycle: if a req is present, go to ACCESS exactly as from IDLE; otherwise go to IDLE.
- Arbitration is round-robin using a `last` pointer:
  - Only one req high: that port wins.
  - Both high: the port != `last` wins.
  - `last` updates to the winner on each grant.
  - After reset `last` = 1, so port 0 wins the first tie.
- Writes produce no rvalid. A write's gnt is its completion indication.
- req still high in RESP counts as a new request. Requesters must drop req on the edge following the cycle gnt is seen, unless they want another access.
- `mem_address` / `mem_data_in` hold their last value when idle. `mem_write_en` is high only in ACCESS.

## Timing
- Reset (async, immediate) forces:
  - state = IDLE, `last` = 1;
  - gnt0/1, rvalid0/1, `mem_write_en` = 0;
  - rdata0/1, `mem_address`, `mem_data_in` = 0.
- Reset mid-ACCESS drops `mem_write_en` at once. The write may or may not have landed. No rvalid is issued; the request is lost and the requester must re-request.
- Read latency, with req sampled high at edge E0:
  - gnt high in cycle E0..E1;
  - memory reads at E1;
  - rdata/rvalid registered at E2;
  - rvalid high in cycle E2..E3.
  - Total: req-sample to rvalid = 2 edges.
- Throughput: back-to-back grants every 2 cycles (ACCESS, RESP, ACCESS, ...). Each port gets at most every other grant under contention.
- rvalid of access k and gnt of access k+1 may be high in the same cycle.
- Read-after-write to the same address from either port returns the new data, because accesses are serialized.
- Address wrap: none internal; `addr` is passed through as is (0xFF is a legal final word).

## Test plan
- Reset: assert rst mid-cycle with req0 high -> all outputs 0 immediately; after release with req0=1, addr0=0x10, we0=0: gnt0 pulses 1 edge later, and `mem_write_en` stays 0.
- Single write then read: port 0 writes 0xBEEF to 0x05; next request reads 0x05 -> no rvalid0 on the write; rvalid0 pulses with rdata0=0xBEEF exactly 2 edges after the read req is sampled.
- Tie arbitration: both ports request reads of 0x01 / 0x02 (preloaded 0x1111 / 0x2222) every cycle -> gnt order 0,1,0,1; grants spaced 2 cycles apart; rdata0=0x1111, rdata1=0x2222.
- Cross-port coherence: port 1 writes 0x00FF→0xA5A5 while port 0 waits to read 0x00FF -> port 0 receives 0xA5A5 if granted after the write, else the prior value; ordering matches the gnt sequence.
- Held req: port 0 keeps req0 high through RESP with we0=0 -> a second grant is issued; two rvalid0 pulses occur; `last` alternation is respected when req1 joins.
- Reset during ACCESS of a read -> no rvalid is ever asserted for it; the next access after reset is granted to port 0 on a tie.

Source files
------------

// File: rtl/mem_arbiter_16bit.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory with a
// one-cycle registered read; one access completes every two cycles under back-to-back load.
module mem_arbiter_16bit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last;
  logic   r_win;
  logic   r_we;

  logic              w_any;
  logic              w_win;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // On a tie the port that did not win last time goes next.
  assign w_any   = req0 | req1;
  assign w_win   = (req0 & req1) ? ~r_last : req1;
  assign w_we    = w_win ? we1 : we0;
  assign w_addr  = w_win ? addr1 : addr0;
  assign w_wdata = w_win ? wdata1 : wdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_win        <= 1'b0;
      r_we         <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      mem_address  <= '0;
      mem_data_in  <= '0;
      mem_write_en <= 1'b0;
    end else begin
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      mem_write_en <= 1'b0;
      case (r_state)
        ACCESS: r_state <= RESP;
        IDLE, RESP: begin
          // Memory data_out is valid in RESP; return it to whoever issued the read.
          if (r_state == RESP && !r_we) begin
            if (r_win) begin
              rdata1  <= mem_data_out;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= mem_data_out;
              rvalid0 <= 1'b1;
            end
          end
          if (w_any) begin
            mem_address  <= w_addr;
            mem_data_in  <= w_wdata;
            mem_write_en <= w_we;
            gnt0         <= ~w_win;
            gnt1         <= w_win;
            r_win        <= w_win;
            r_we         <= w_we;
            r_last       <= w_win;
            r_state      <= ACCESS;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_16bit.sv
// Scoreboard bench for mem_arbiter_16bit: a slot-schedule reference model predicts grants,
// memory commands and read returns; a negedge monitor compares the DUT against them.
module tb_mem_arbiter_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_write_en;
  logic [15:0] rdata0, rdata1, mem_data_in;
  logic [15:0] mem_data_out;
  logic [7:0]  mem_address;

  always #5 clk = ~clk;

  mem_arbiter_16bit #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .mem_data_out(mem_data_out)
  );

  // Stand-in for the 256x16 synchronous memory (registered read).
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem_data_out <= '0;
    end else begin
      if (mem_write_en) mem[mem_address] <= mem_data_in;
      mem_data_out <= mem[mem_address];
    end
  end

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          gap;
  } txn_t;

  typedef struct {
    int          cyc;
    bit          port;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t gq[$];
  exp_t rq[$];

  // Reference model state: per-port pending transactions and the access-slot schedule.
  txn_t        pq [2][$];
  txn_t        cur [2];
  bit          have [2];
  bit          active [2];
  bit          granted [2];
  bit          m_last = 1'b1;
  int          t_free = 0;
  int          gcyc = -1;
  logic [15:0] mmem [256];
  logic [7:0]  aset [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic push(input int p, input bit we, input logic [7:0] a, input logic [15:0] d,
                      input int gap);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.gap = gap;
    pq[p].push_back(t);
  endtask

  // One cycle of stimulus: update requesters at negedge, then predict the next edge.
  task automatic step();
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (granted[p]) begin
        active[p] = 1'b0; have[p] = 1'b0; granted[p] = 1'b0;
      end
      if (!have[p] && pq[p].size() != 0) begin
        cur[p] = pq[p].pop_front();
        have[p] = 1'b1;
      end
      if (have[p] && !active[p]) begin
        if (cur[p].gap == 0) active[p] = 1'b1;
        else cur[p].gap = cur[p].gap - 1;
      end
    end
    req0 = active[0]; we0 = active[0] & cur[0].we; addr0 = cur[0].addr; wdata0 = cur[0].wdata;
    req1 = active[1]; we1 = active[1] & cur[1].we; addr1 = cur[1].addr; wdata1 = cur[1].wdata;
    if (!rst && (cyc + 1) >= t_free && (active[0] || active[1])) begin
      int   w;
      exp_t e;
      if (active[0] && active[1]) w = m_last ? 0 : 1;
      else w = active[1] ? 1 : 0;
      m_last = (w == 1);
      granted[w] = 1'b1;
      t_free = cyc + 3;
      gcyc = cyc + 1;
      e.cyc = cyc + 1; e.port = (w == 1); e.we = cur[w].we;
      e.addr = cur[w].addr; e.data = cur[w].wdata;
      gq.push_back(e);
      if (cur[w].we) begin
        mmem[cur[w].addr] = cur[w].wdata;
      end else begin
        e.cyc = cyc + 3;
        e.data = mmem[cur[w].addr];
        rq.push_back(e);
      end
    end
  endtask

  task automatic model_reset();
    pq[0].delete(); pq[1].delete();
    for (int p = 0; p < 2; p++) begin
      active[p] = 1'b0; have[p] = 1'b0; granted[p] = 1'b0;
    end
    m_last = 1'b1;
    t_free = 0;
    for (int i = 0; i < 256; i++) mmem[i] = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'({gnt1, gnt0}), 32'd0);
    chk({tag, "_rvalid"}, 32'({rvalid1, rvalid0}), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_write_en), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_address), 32'd0);
    chk({tag, "_mem_din"}, 32'(mem_data_in), 32'd0);
    chk({tag, "_rdata0"}, 32'(rdata0), 32'd0);
    chk({tag, "_rdata1"}, 32'(rdata1), 32'd0);
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    while ((pq[0].size() + pq[1].size() != 0 || have[0] || have[1]) && n < maxc) begin
      step();
      n++;
    end
    chk("idle_budget", 32'(n < maxc), 32'd1);
    repeat (6) step();
    chk("drain", 32'(gq.size() + rq.size()), 32'd0);
  endtask

  // Monitor: pops expectations due this cycle and compares every observable output.
  logic [7:0]  exp_addr = '0;
  logic [15:0] exp_wd = '0;
  logic [15:0] exp_rd [2];
  always @(negedge clk) begin
    logic [1:0] eg, erv;
    logic       ewe;
    exp_t       e;
    if (rst) begin
      gq.delete(); rq.delete();
      exp_addr = '0; exp_wd = '0; exp_rd[0] = '0; exp_rd[1] = '0;
    end
    eg = 2'b00; erv = 2'b00; ewe = 1'b0;
    if (gq.size() != 0 && gq[0].cyc == cyc) begin
      e = gq.pop_front();
      eg = e.port ? 2'b10 : 2'b01;
      ewe = e.we; exp_addr = e.addr; exp_wd = e.data;
    end
    if (rq.size() != 0 && rq[0].cyc == cyc) begin
      e = rq.pop_front();
      erv = e.port ? 2'b10 : 2'b01;
      exp_rd[e.port] = e.data;
    end
    chk("gnt", 32'({gnt1, gnt0}), 32'(eg));
    chk("mem_write_en", 32'(mem_write_en), 32'(ewe));
    chk("mem_address", 32'(mem_address), 32'(exp_addr));
    chk("mem_data_in", 32'(mem_data_in), 32'(exp_wd));
    chk("rvalid", 32'({rvalid1, rvalid0}), 32'(erv));
    chk("rdata0", 32'(rdata0), 32'(exp_rd[0]));
    chk("rdata1", 32'(rdata1), 32'(exp_rd[1]));
  end

  initial begin
    #400000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    aset[0] = 8'h00; aset[1] = 8'h01; aset[2] = 8'h7F; aset[3] = 8'hFF;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("por");
    rst = 1'b0;

    // First access after reset: port 0 read, no write enable.
    push(0, 1'b0, 8'h10, 16'h0000, 0);
    run_idle(50);

    // Write then read back on port 0.
    push(0, 1'b1, 8'h05, 16'hBEEF, 0);
    push(0, 1'b0, 8'h05, 16'h0000, 0);
    run_idle(50);

    // Preload, then both ports read every cycle.
    push(0, 1'b1, 8'h01, 16'h1111, 0);
    push(1, 1'b1, 8'h02, 16'h2222, 0);
    run_idle(50);
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 8'h01, 16'h0000, 0);
      push(1, 1'b0, 8'h02, 16'h0000, 0);
    end
    run_idle(100);

    // Cross-port coherence on the last word.
    push(1, 1'b1, 8'hFF, 16'hA5A5, 0);
    push(0, 1'b0, 8'hFF, 16'h0000, 0);
    push(0, 1'b0, 8'hFF, 16'h0000, 1);
    run_idle(50);

    // Port 0 holds req across RESP, then port 1 joins.
    push(0, 1'b0, 8'h05, 16'h0000, 0);
    push(0, 1'b0, 8'h01, 16'h0000, 0);
    push(0, 1'b0, 8'h02, 16'h0000, 0);
    push(1, 1'b0, 8'h05, 16'h0000, 2);
    run_idle(80);

    // Reset while a read is in ACCESS with req0 still high.
    push(0, 1'b0, 8'h05, 16'h0000, 0);
    push(0, 1'b0, 8'h01, 16'h0000, 0);
    k = 0;
    do begin
      step();
      k++;
    end while (gcyc != cyc + 1 && k < 20);
    chk("rst_grant_seen", 32'(gcyc == cyc + 1), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    push(0, 1'b0, 8'h05, 16'h0000, 0);
    push(1, 1'b0, 8'h01, 16'h0000, 0);
    run_idle(50);

    // Randomized traffic from both ports.
    for (int i = 0; i < 200; i++) begin
      for (int p = 0; p < 2; p++) begin
        push(p, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0) ? 8'($urandom) : aset[$urandom_range(0, 3)],
             16'($urandom), int'($urandom_range(0, 3)));
      end
    end
    run_idle(5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
